// File: rtl/vga_pkg.sv
// Shared 800x600@60 timing constants and counter types for the video path.
// Latency: none (declarations only).
// Backpressure: none; the pixel timing is free-running.
package vga_pkg;

  // 40 MHz pixel clock, 800x600@60 (VESA), positive syncs
  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FP_DEF     = 40;
  localparam int H_SYNC_DEF   = 128;
  localparam int H_BP_DEF     = 88;
  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 1056

  localparam int V_ACTIVE_DEF = 600;
  localparam int V_FP_DEF     = 1;
  localparam int V_SYNC_DEF   = 4;
  localparam int V_BP_DEF     = 23;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 628

  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;
  localparam int FCNT_W = 16;

  typedef logic [HCNT_W-1:0] hcnt_t;
  typedef logic [VCNT_W-1:0] vcnt_t;
  typedef logic [FCNT_W-1:0] fcnt_t;

  // Half-open window test lo <= cnt < hi at horizontal-counter width
  function automatic logic in_window(input hcnt_t cnt, input hcnt_t lo, input hcnt_t hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bundle of the raster timing outputs handed to the renderer.
// Latency: none (wires only).
// Backpressure: none; the consumer must keep up with the pixel clock.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic  h_sync;
  logic  v_sync;
  logic  h_disp;
  logic  v_disp;
  hcnt_t h_loc;
  vcnt_t v_loc;
  logic  line_start;
  logic  frame_tick;
  fcnt_t frame_cnt;

  modport master (
    output h_sync, v_sync, h_disp, v_disp, h_loc, v_loc, line_start, frame_tick, frame_cnt
  );

  modport slave (
    input  h_sync, v_sync, h_disp, v_disp, h_loc, v_loc, line_start, frame_tick, frame_cnt
  );

endinterface

// File: rtl/vga_timing_gen_sync_counter.sv
// Wrap-at-N counter with enable; wrap_o flags the enabled cycle at N-1.
// Latency: count registered; wrap_o is combinational from the count.
// Backpressure: none; en_i simply holds the count.
module sync_counter #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap_o = en_i && (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  // Next count: wrap to zero at N-1, otherwise step when enabled
  always_comb begin
    cnt_d = cnt_q;
    if (wrap_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register with synchronous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v counters, syncs, display enables, frame strobes.
// Latency: every output is one cycle behind the counters, all mutually aligned.
// Backpressure: none; free-running at the pixel clock.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOT > 2047) begin : g_h_total_err
    $error("H_TOTAL does not fit the 11-bit horizontal counter");
  end
  if (V_TOT > 1023) begin : g_v_total_err
    $error("V_TOTAL does not fit the 10-bit vertical counter");
  end

  localparam hcnt_t H_ACT_C  = hcnt_t'(H_ACTIVE);
  localparam hcnt_t HS_START = hcnt_t'(H_ACTIVE + H_FP);
  localparam hcnt_t HS_END   = hcnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam vcnt_t V_ACT_C  = vcnt_t'(V_ACTIVE);
  localparam vcnt_t V_LAST_V = vcnt_t'(V_ACTIVE - 1);
  localparam vcnt_t VS_START = vcnt_t'(V_ACTIVE + V_FP);
  localparam vcnt_t VS_END   = vcnt_t'(V_ACTIVE + V_FP + V_SYNC);

  hcnt_t h_cnt;
  vcnt_t v_cnt;
  logic  h_wrap;
  logic  v_wrap;

  sync_counter #(.N(H_TOT), .W(HCNT_W)) u_h_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (1'b1),
    .cnt_o  (h_cnt),
    .wrap_o (h_wrap)
  );

  // v_cnt only moves on the last pixel of a line, so its wrap is the frame wrap
  sync_counter #(.N(V_TOT), .W(VCNT_W)) u_v_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (h_wrap),
    .cnt_o  (v_cnt),
    .wrap_o (v_wrap)
  );

  fcnt_t frame_cnt_q;
  fcnt_t frame_cnt_d;
  fcnt_t frame_out_q;
  hcnt_t h_loc_q;
  vcnt_t v_loc_q;
  logic  h_disp_q;
  logic  v_disp_q;
  logic  h_sync_q;
  logic  v_sync_q;
  logic  line_start_q;
  logic  frame_tick_q;

  // Completed-frame count; 16-bit arithmetic wraps 65535 -> 0 naturally
  assign frame_cnt_d = v_wrap ? frame_cnt_q + 16'd1 : frame_cnt_q;

  // Output stage: decode the current counter state into registered outputs.
  // frame_cnt is staged once more so it changes together with v_loc returning to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q  <= '0;
      frame_out_q  <= '0;
      h_loc_q      <= '0;
      v_loc_q      <= '0;
      h_disp_q     <= 1'b0;
      v_disp_q     <= 1'b0;
      h_sync_q     <= ~SYNC_POL;
      v_sync_q     <= ~SYNC_POL;
      line_start_q <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      frame_out_q  <= frame_cnt_q;
      h_loc_q      <= h_cnt;
      v_loc_q      <= v_cnt;
      h_disp_q     <= (h_cnt < H_ACT_C);
      v_disp_q     <= (v_cnt < V_ACT_C);
      h_sync_q     <= in_window(h_cnt, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
      v_sync_q     <= in_window({1'b0, v_cnt}, {1'b0, VS_START}, {1'b0, VS_END}) ?
                      SYNC_POL : ~SYNC_POL;
      line_start_q <= (h_cnt == '0);
      frame_tick_q <= (h_cnt == H_ACT_C) && (v_cnt == V_LAST_V);
    end
  end

  assign vga.h_loc      = h_loc_q;
  assign vga.v_loc      = v_loc_q;
  assign vga.h_disp     = h_disp_q;
  assign vga.v_disp     = v_disp_q;
  assign vga.h_sync     = h_sync_q;
  assign vga.v_sync     = v_sync_q;
  assign vga.line_start = line_start_q;
  assign vga.frame_tick = frame_tick_q;
  assign vga.frame_cnt  = frame_out_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a shrunken-raster instance checked cycle by cycle
// against a reference model, plus a default 800x600 instance for one full line.
module tb_vga_timing_gen;

  // Small raster: 32 pixels x 16 lines = 512 cycles per frame
  localparam int FRAME = 512;

  typedef struct packed {
    logic [10:0] h_loc;
    logic [9:0]  v_loc;
    logic        h_disp;
    logic        v_disp;
    logic        h_sync;
    logic        v_sync;
    logic        line_start;
    logic        frame_tick;
    logic [15:0] frame_cnt;
  } out_t;

  typedef struct packed {
    logic [31:0] cyc;
    out_t        exp;
  } vec_t;

  logic clk;
  logic rst_n;
  logic force_frame;

  int errors = 0;
  int checks = 0;

  vga_timing_gen_if vif_s ();
  vga_timing_gen_if vif_d ();

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (vif_s)
  );

  vga_timing_gen dut_d (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (vif_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic out_t cur_out();
    out_t o;
    o.h_loc      = vif_s.h_loc;
    o.v_loc      = vif_s.v_loc;
    o.h_disp     = vif_s.h_disp;
    o.v_disp     = vif_s.v_disp;
    o.h_sync     = vif_s.h_sync;
    o.v_sync     = vif_s.v_sync;
    o.line_start = vif_s.line_start;
    o.frame_tick = vif_s.frame_tick;
    o.frame_cnt  = vif_s.frame_cnt;
    return o;
  endfunction

  // ---------------- reference model + scoreboard ----------------
  logic [10:0] mh = '0;
  logic [9:0]  mv = '0;
  logic [15:0] mf = '0;
  out_t        sb_q[$];
  out_t        sb_e;
  out_t        sb_a;

  always @(posedge clk) begin
    if (!rst_n) begin
      sb_e = '0;
      mh = '0; mv = '0; mf = '0;
    end else begin
      sb_e.h_loc      = mh;
      sb_e.v_loc      = mv;
      sb_e.h_disp     = (mh < 11'd16);
      sb_e.v_disp     = (mv < 10'd10);
      sb_e.h_sync     = (mh >= 11'd20) && (mh <= 11'd25);
      sb_e.v_sync     = (mv >= 10'd11) && (mv <= 10'd12);
      sb_e.line_start = (mh == 11'd0);
      sb_e.frame_tick = (mh == 11'd16) && (mv == 10'd9);
      sb_e.frame_cnt  = mf;
      if (mh == 11'd31) begin
        mh = '0;
        if (mv == 10'd15) begin
          mv = '0;
          mf = mf + 16'd1;
        end else begin
          mv = mv + 10'd1;
        end
      end else begin
        mh = mh + 11'd1;
      end
      if (force_frame) mf = 16'hFFFF;
    end
    sb_q.push_back(sb_e);
  end

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_e = sb_q.pop_front();
      sb_a = cur_out();
      checks++;
      if (sb_a !== sb_e) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got h=%0d v=%0d hd=%b vd=%b hs=%b vs=%b ls=%b ft=%b fc=%0d expected h=%0d v=%0d hd=%b vd=%b hs=%b vs=%b ls=%b ft=%b fc=%0d",
                 $time, sb_a.h_loc, sb_a.v_loc, sb_a.h_disp, sb_a.v_disp, sb_a.h_sync,
                 sb_a.v_sync, sb_a.line_start, sb_a.frame_tick, sb_a.frame_cnt,
                 sb_e.h_loc, sb_e.v_loc, sb_e.h_disp, sb_e.v_disp, sb_e.h_sync,
                 sb_e.v_sync, sb_e.line_start, sb_e.frame_tick, sb_e.frame_cnt);
      end
    end
  end

  // ---------------- hand-computed vectors ----------------
  function automatic vec_t mk(input int c, input int h, input int v, input bit hd, input bit vd,
                              input bit hs, input bit vs, input bit ls, input bit ft, input int fc);
    vec_t r;
    r.cyc            = c;
    r.exp.h_loc      = 11'(h);
    r.exp.v_loc      = 10'(v);
    r.exp.h_disp     = hd;
    r.exp.v_disp     = vd;
    r.exp.h_sync     = hs;
    r.exp.v_sync     = vs;
    r.exp.line_start = ls;
    r.exp.frame_tick = ft;
    r.exp.frame_cnt  = 16'(fc);
    return r;
  endfunction

  localparam int NV = 16;
  vec_t vecs[NV];

  int vis_cnt, tick_cnt, max_h, max_v, vs_cyc;
  int hs_cnt, hs_first, hs_rises, ls_d;
  bit hs_prev;
  bit found;
  out_t o;

  initial begin
    //            cyc   h   v  hd vd hs vs ls ft fc
    vecs[0]  = mk(0,    0,  0, 1, 1, 0, 0, 1, 0, 0);
    vecs[1]  = mk(15,   15, 0, 1, 1, 0, 0, 0, 0, 0);
    vecs[2]  = mk(16,   16, 0, 0, 1, 0, 0, 0, 0, 0);
    vecs[3]  = mk(19,   19, 0, 0, 1, 0, 0, 0, 0, 0);
    vecs[4]  = mk(20,   20, 0, 0, 1, 1, 0, 0, 0, 0);
    vecs[5]  = mk(25,   25, 0, 0, 1, 1, 0, 0, 0, 0);
    vecs[6]  = mk(26,   26, 0, 0, 1, 0, 0, 0, 0, 0);
    vecs[7]  = mk(32,   0,  1, 1, 1, 0, 0, 1, 0, 0);
    vecs[8]  = mk(304,  16, 9, 0, 1, 0, 0, 0, 1, 0);
    vecs[9]  = mk(320,  0, 10, 1, 0, 0, 0, 1, 0, 0);
    vecs[10] = mk(352,  0, 11, 1, 0, 0, 1, 1, 0, 0);
    vecs[11] = mk(415,  31, 12, 0, 0, 0, 1, 0, 0, 0);
    vecs[12] = mk(416,  0, 13, 1, 0, 0, 0, 1, 0, 0);
    vecs[13] = mk(511,  31, 15, 0, 0, 0, 0, 0, 0, 0);
    vecs[14] = mk(512,  0,  0, 1, 1, 0, 0, 1, 0, 1);
    vecs[15] = mk(1328, 16, 9, 0, 1, 0, 0, 0, 1, 2);

    force_frame = 1'b0;
    rst_n = 1'b0;
    vis_cnt = 0; tick_cnt = 0; max_h = 0; max_v = 0; vs_cyc = 0;
    hs_cnt = 0; hs_first = -1; hs_rises = 0; ls_d = 0; hs_prev = 1'b0;

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_h_sync", 32'(vif_s.h_sync), 0);
    chk("rst_line_start", 32'(vif_s.line_start), 0);
    chk("rst_def_h_sync", 32'(vif_d.h_sync), 0);
    chk("rst_def_h_disp", 32'(vif_d.h_disp), 0);

    // Release; cycle k is the k-th sample after the first running edge
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3 * FRAME; k++) begin
      for (int i = 0; i < NV; i++) begin
        if (vecs[i].cyc == 32'(k)) begin
          o = cur_out();
          checks++;
          if (o !== vecs[i].exp) begin
            errors++;
            $display("FAIL vec cyc=%0d: got %h expected %h", k, o, vecs[i].exp);
          end
        end
      end
      if (vif_s.h_disp && vif_s.v_disp) vis_cnt++;
      if (vif_s.frame_tick) begin
        tick_cnt++;
        chk("tick_h_loc", 32'(vif_s.h_loc), 16);
        chk("tick_v_loc", 32'(vif_s.v_loc), 9);
      end
      if (int'(vif_s.h_loc) > max_h) max_h = int'(vif_s.h_loc);
      if (int'(vif_s.v_loc) > max_v) max_v = int'(vif_s.v_loc);
      if (k < FRAME && vif_s.v_sync) vs_cyc++;
      // Default-timing instance: one full 1056-pixel line
      if (k < 1056) begin
        if (vif_d.h_sync) begin
          if (hs_cnt == 0) hs_first = int'(vif_d.h_loc);
          hs_cnt++;
        end
        if (vif_d.h_sync && !hs_prev) hs_rises++;
        hs_prev = vif_d.h_sync;
        if (vif_d.line_start) ls_d++;
        if (k == 0) chk("def_ls_cyc0", 32'(vif_d.line_start), 1);
      end
      if (k == 1056) begin
        chk("def_ls_cyc1056", 32'(vif_d.line_start), 1);
        chk("def_h_loc_cyc1056", 32'(vif_d.h_loc), 0);
        chk("def_v_loc_cyc1056", 32'(vif_d.v_loc), 1);
      end
      @(negedge clk);
    end
    chk("visible_cycles_3_frames", 32'(vis_cnt), 480);
    chk("frame_ticks_3_frames", 32'(tick_cnt), 3);
    chk("max_h_loc", 32'(max_h), 31);
    chk("max_v_loc", 32'(max_v), 15);
    chk("v_sync_cycles_frame0", 32'(vs_cyc), 64);
    chk("def_h_sync_width", 32'(hs_cnt), 128);
    chk("def_h_sync_start", 32'(hs_first), 840);
    chk("def_h_sync_pulses", 32'(hs_rises), 1);
    chk("def_line_start_count", 32'(ls_d), 1);
    chk("frame_cnt_after_3", 32'(vif_s.frame_cnt), 3);

    // Reset while both syncs are active (h=22, v=11)
    found = 1'b0;
    for (int n = 0; n < 1024 && !found; n++) begin
      if (vif_s.h_loc == 11'd22 && vif_s.v_loc == 10'd11) found = 1'b1;
      else @(negedge clk);
    end
    chk("reached_sync_point", 32'(found), 1);
    chk("sync_point_h_sync", 32'(vif_s.h_sync), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_h_sync", 32'(vif_s.h_sync), 0);
    chk("midrst_v_sync", 32'(vif_s.v_sync), 0);
    chk("midrst_h_loc", 32'(vif_s.h_loc), 0);
    chk("midrst_v_loc", 32'(vif_s.v_loc), 0);
    chk("midrst_h_disp", 32'(vif_s.h_disp), 0);
    chk("midrst_frame_cnt", 32'(vif_s.frame_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_h_loc", 32'(vif_s.h_loc), 0);
    chk("restart_line_start", 32'(vif_s.line_start), 1);
    chk("restart_disp", 32'({vif_s.h_disp, vif_s.v_disp}), 3);

    // Preload frame count with 65535 mid-frame, then cross the frame wrap
    repeat (100) @(negedge clk);
    force dut.frame_cnt_d = 16'hFFFF;
    force_frame = 1'b1;
    @(negedge clk);
    release dut.frame_cnt_d;
    force_frame = 1'b0;
    repeat (410) @(negedge clk);
    chk("pre_wrap_h_loc", 32'(vif_s.h_loc), 31);
    chk("pre_wrap_frame_cnt", 32'(vif_s.frame_cnt), 65535);
    @(negedge clk);
    chk("wrap_frame_cnt", 32'(vif_s.frame_cnt), 0);
    chk("wrap_v_loc", 32'(vif_s.v_loc), 0);
    chk("wrap_line_start", 32'(vif_s.line_start), 1);
    repeat (40) @(negedge clk);

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 Parameter H_FP, default 40, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 128, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 88, horizontal back porch in pixels; H_TOTAL = 1056.
REQ-005 Parameter V_ACTIVE, default 600, visible lines per frame.
REQ-006 Parameters V_FP / V_SYNC / V_BP, defaults 1 / 4 / 23, in lines; V_TOTAL = 628.
REQ-007 Parameter SYNC_POL, default 1, sync active level (1 = positive, as required for 800x600@60).
REQ-008 clk  in  1  pixel clock, 40 MHz; the single clock of the block.
REQ-009 rst_n  in  1  reset, synchronous, active-low.
REQ-010 h_sync  out  1  horizontal sync, active level SYNC_POL.
REQ-011 v_sync  out  1  vertical sync, active level SYNC_POL.
REQ-012 h_disp  out  1  high while the horizontal position is within the visible region.
REQ-013 v_disp  out  1  high while the vertical position is within the visible region.
REQ-014 h_loc  out  11  current pixel column; 0..H_TOTAL-1.
REQ-015 v_loc  out  10  current line; 0..V_TOTAL-1.
REQ-016 line_start  out  1  one-cycle pulse on the first pixel (h_loc=0) of every line.
REQ-017 frame_tick  out  1  one-cycle pulse on the first blanking pixel after the last visible pixel of a frame; this is the game-logic update strobe.
REQ-018 frame_cnt  out  16  number of completed frames since reset; wraps modulo 2^16.

Function
REQ-019 The block SHALL hold an 11-bit h_cnt that increments by 1 each clk and wraps from H_TOTAL-1 to 0.
REQ-020 The block SHALL hold a 10-bit v_cnt that increments only when h_cnt wraps, and wraps from V_TOTAL-1 to 0.
REQ-021 h_disp SHALL be 1 iff h_cnt < H_ACTIVE; v_disp SHALL be 1 iff v_cnt < V_ACTIVE.
REQ-022 h_sync SHALL be at SYNC_POL iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (cycles 840..967 by default).
REQ-023 v_sync SHALL be at SYNC_POL iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (lines 601..604 by default).
REQ-024 All outputs SHALL be registered; every output SHALL reflect the counter state of the same cycle, with exactly one cycle of latency from the counters, so that h_loc, v_loc, h_disp, v_disp, h_sync and v_sync stay mutually aligned.
REQ-025 frame_tick SHALL assert for exactly one cycle when h_cnt = H_ACTIVE and v_cnt = V_ACTIVE-1, i.e. once per frame.
REQ-026 frame_cnt SHALL increment when v_cnt wraps from V_TOTAL-1 to 0 at h_cnt wrap, and SHALL wrap from 65535 to 0.
REQ-027 line_start SHALL assert whenever h_cnt = 0, including the line after a v_cnt wrap.
REQ-028 Counter comparisons SHALL use the declared widths; parameter sums SHALL be evaluated at elaboration, and H_TOTAL > 2047 or V_TOTAL > 1023 SHALL be an elaboration error.

Reset
REQ-029 While rst_n=0 at a clk edge, h_cnt, v_cnt and frame_cnt SHALL load 0 and h_loc=0, v_loc=0, h_disp=0, v_disp=0, h_sync=~SYNC_POL, v_sync=~SYNC_POL, line_start=0, frame_tick=0.
REQ-030 On the first edge with rst_n=1, counting SHALL start at (0,0) and the outputs SHALL show h_loc=0, v_loc=0, h_disp=1, v_disp=1, line_start=1 on the following cycle.
REQ-031 Reset asserted mid-line or mid-frame SHALL take effect at the next edge with no partial sync pulse extended beyond that edge.

Structure
REQ-032 The default timing constants (800x600@60 set) and the derived H_TOTAL/V_TOTAL SHALL live in a shared package vga_pkg, which the snake renderer also imports.
REQ-033 The block SHALL instantiate one sub-module, sync_counter: a parameterised wrap-at-N counter with an enable input and a wrap pulse output, used once for horizontal and once for vertical.

Verification
REQ-034 Release rst_n and run 1056 cycles -> h_sync active for exactly 128 consecutive cycles starting at h_loc=840; line_start pulses at cycles 0 and 1056.
REQ-035 Run one full frame of 1056*628 = 663168 cycles -> v_sync active for exactly 4 lines (v_loc 601..604); frame_cnt goes 0->1 at the v wrap.
REQ-036 Check the visible window -> h_disp&&v_disp high for exactly 480000 cycles per frame; frame_tick occurs once, at h_loc=800, v_loc=599.
REQ-037 Assert rst_n=0 at h_loc=900 of line 602 (sync active) -> next cycle all outputs take reset values and both syncs are inactive.
REQ-038 Force frame_cnt to 65535 and run one frame -> frame_cnt wraps to 0 with no other glitch.
REQ-039 Free-run 3 frames -> h_loc and v_loc never exceed 1055 and 627 respectively.
